spike_rate_decoder: RTL and testbench

Counts output spikes of a LIF neuron over a fixed window of clock cycles and reports the spike count, and optionally the minimum inter-spike interval, through a valid/ready handshake. It converts a neuron's spike train back into an 8-bit magnitude, the inverse of the neuron's current-to-spike encoding. It sits downstream of a neuron's `spike` output and feeds readout or learning logic.

---
 rtl/spike_rate_decoder_if.sv | 22 ++
 rtl/spike_rate_decoder.sv | 165 ++++++++++++++++
 tb/tb_spike_rate_decoder.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/spike_rate_decoder_if.sv
// Result handshake bundle for spike_rate_decoder.
// master drives the result, slave accepts it.
interface spike_rate_decoder_if;
  logic [7:0] rate;
  logic [7:0] isi_min;
  logic       rate_valid;
  logic       rate_ready;

  modport master (
    output rate,
    output isi_min,
    output rate_valid,
    input  rate_ready
  );

  modport slave (
    input  rate,
    input  isi_min,
    input  rate_valid,
    output rate_ready
  );
endinterface

// File: rtl/spike_rate_decoder.sv
// Windowed spike counter with optional min inter-spike interval.
// Optional ISI logic: define SPIKE_RATE_DECODER_ISI_EN.
module spike_rate_decoder #(
  parameter int WINDOW = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic spike,
  input  logic start,
  input  logic cont,
  output logic busy,
  output logic missed,
  spike_rate_decoder_if.master rd
);

  localparam logic [7:0] LAST = 8'(WINDOW - 1);

  typedef enum logic [1:0] {
    IDLE,
    COUNT,
    HOLD
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] win_q, win_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] rate_q, rate_d;
  logic       valid_q, valid_d;
  logic       busy_q, busy_d;
  logic       missed_q, missed_d;
  logic       started_q, started_d;
  logic       clr;
  logic       last;

  assign last = (state_q == COUNT) && (win_q == LAST);

  // Next-state, counters and result capture.
  always_comb begin
    state_d   = state_q;
    win_d     = win_q;
    cnt_d     = cnt_q;
    rate_d    = rate_q;
    valid_d   = valid_q;
    missed_d  = missed_q;
    started_d = started_q;
    clr       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (spike && started_q) missed_d = 1'b1;
        if (start) begin
          state_d   = COUNT;
          started_d = 1'b1;
          clr       = 1'b1;
        end
      end
      COUNT: begin
        cnt_d = cnt_q + {7'd0, spike};
        if (last) begin
          state_d = HOLD;
          rate_d  = cnt_d;
          valid_d = 1'b1;
        end else begin
          win_d = win_q + 8'd1;
        end
      end
      HOLD: begin
        if (spike) missed_d = 1'b1;
        if (rd.rate_ready) begin
          valid_d = 1'b0;
          if (cont) begin
            state_d = COUNT;
            clr     = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (clr) begin
      win_d = 8'd0;
      cnt_d = 8'd0;
    end
    busy_d = (state_d != IDLE);
  end

  // Main state and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      win_q     <= 8'd0;
      cnt_q     <= 8'd0;
      rate_q    <= 8'd0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      missed_q  <= 1'b0;
      started_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      win_q     <= win_d;
      cnt_q     <= cnt_d;
      rate_q    <= rate_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      missed_q  <= missed_d;
      started_q <= started_d;
    end
  end

  assign rd.rate       = rate_q;
  assign rd.rate_valid = valid_q;
  assign busy          = busy_q;
  assign missed        = missed_q;

`ifdef SPIKE_RATE_DECODER_ISI_EN
  logic [7:0] ivl_q, ivl_d;
  logic [7:0] min_q, min_d;
  logic [7:0] isi_q, isi_d;
  logic       prev_q, prev_d;

  // Interval since last spike; min kept only once a prior spike exists.
  always_comb begin
    ivl_d  = ivl_q;
    min_d  = min_q;
    isi_d  = isi_q;
    prev_d = prev_q;
    if (state_q == COUNT) begin
      if (spike) begin
        if (prev_q && (min_q == 8'd0 || ivl_q < min_q))
          min_d = ivl_q;
        prev_d = 1'b1;
        ivl_d  = 8'd1;
      end else if (ivl_q != 8'hFF) begin
        ivl_d = ivl_q + 8'd1;
      end
      if (last) isi_d = min_d;
    end
    if (clr) begin
      ivl_d  = 8'd0;
      min_d  = 8'd0;
      prev_d = 1'b0;
    end
  end

  // ISI tracking registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      ivl_q  <= 8'd0;
      min_q  <= 8'd0;
      isi_q  <= 8'd0;
      prev_q <= 1'b0;
    end else begin
      ivl_q  <= ivl_d;
      min_q  <= min_d;
      isi_q  <= isi_d;
      prev_q <= prev_d;
    end
  end

  assign rd.isi_min = isi_q;
`else
  assign rd.isi_min = 8'd0;
`endif

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Randomized bench for spike_rate_decoder against a window-level model.
// Honors SPIKE_RATE_DECODER_ISI_EN for the expected isi_min.
module tb_spike_rate_decoder;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst, spike, start, cont;
  logic busy, missed;

  spike_rate_decoder_if rd ();

  spike_rate_decoder #(.WINDOW(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .spike  (spike),
    .start  (start),
    .cont   (cont),
    .busy   (busy),
    .missed (missed),
    .rd     (rd.master)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // model: 0 idle, 1 counting, 2 holding result
  int m_st = 0;
  int m_idx = 0;
  bit rec[W];
  int m_rate = 0;
  int m_isi = 0;
  bit m_valid = 0;
  bit m_missed = 0;
  bit m_started = 0;

  function automatic int calc_isi();
    int last_pos = -1;
    int mn = 0;
    int d;
    for (int i = 0; i < W; i++) begin
      if (rec[i]) begin
        if (last_pos >= 0) begin
          d = i - last_pos;
          if (d > 255) d = 255;
          if (mn == 0 || d < mn) mn = d;
        end
        last_pos = i;
      end
    end
    return mn;
  endfunction

  function automatic int calc_rate();
    int s = 0;
    for (int i = 0; i < W; i++) s += int'(rec[i]);
    return s;
  endfunction

  task automatic open_window();
    m_st = 1;
    m_idx = 0;
    for (int i = 0; i < W; i++) rec[i] = 1'b0;
  endtask

  task automatic model(input bit r, st, sp, co, rdy);
    if (r) begin
      m_st = 0; m_rate = 0; m_isi = 0;
      m_valid = 0; m_missed = 0; m_started = 0;
    end else begin
      case (m_st)
        0: begin
          if (sp && m_started) m_missed = 1;
          if (st) begin
            m_started = 1;
            open_window();
          end
        end
        1: begin
          rec[m_idx] = sp;
          if (m_idx == W - 1) begin
            m_rate = calc_rate();
`ifdef SPIKE_RATE_DECODER_ISI_EN
            m_isi = calc_isi();
`else
            m_isi = 0;
`endif
            m_valid = 1;
            m_st = 2;
          end else begin
            m_idx++;
          end
        end
        default: begin
          if (sp) m_missed = 1;
          if (rdy) begin
            m_valid = 0;
            if (co) open_window();
            else m_st = 0;
          end
        end
      endcase
    end
  endtask

  task automatic cyc(input bit r, st, sp, co, rdy);
    rst = r; start = st; spike = sp; cont = co;
    rd.rate_ready = rdy;
    @(posedge clk);
    model(r, st, sp, co, rdy);
    #1;
    chk("valid", 32'(rd.rate_valid), 32'(m_valid));
    chk("busy", 32'(busy), 32'(m_st != 0));
    chk("missed", 32'(missed), 32'(m_missed));
    chk("rate", 32'(rd.rate), 32'(m_rate));
    chk("isi", 32'(rd.isi_min), 32'(m_isi));
  endtask

  function automatic int exp_isi(input int v);
`ifdef SPIKE_RATE_DECODER_ISI_EN
    return v;
`else
    return 0 * v;
`endif
  endfunction

  logic [7:0] hold_rate, hold_isi;

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1; start = 0; spike = 0; cont = 0;
    rd.rate_ready = 0;

    // reset state
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 1, 0, 1);
    chk("rst_rate", 32'(rd.rate), 0);
    chk("rst_valid", 32'(rd.rate_valid), 0);

    // constant spikes: valid at k+33, rate 32, isi 1
    cyc(0, 1, 1, 0, 1);
    for (int j = 0; j < W; j++) cyc(0, 0, 1, 0, 1);
    chk("s1_valid", 32'(rd.rate_valid), 1);
    chk("s1_rate", 32'(rd.rate), 32);
    chk("s1_isi", 32'(rd.isi_min), 32'(exp_isi(1)));
    cyc(0, 0, 0, 0, 1);
    chk("s1_idle_busy", 32'(busy), 0);
    chk("s1_vdrop", 32'(rd.rate_valid), 0);

    // every 4th cycle plus an extra spike 2 after the last
    cyc(1, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 1);
    for (int j = 0; j < W; j++)
      cyc(0, 0, (j % 4 == 0) || (j == 30), 0, 1);
    chk("s2_rate", 32'(rd.rate), 9);
    chk("s2_isi", 32'(rd.isi_min), 32'(exp_isi(2)));
    cyc(0, 0, 0, 0, 1);

    // backpressure with spikes in HOLD
    cyc(0, 1, 0, 0, 0);
    for (int j = 0; j < W; j++)
      cyc(0, 0, 1'($urandom_range(0, 1)), 0, 1'($urandom_range(0, 1)));
    hold_rate = rd.rate;
    hold_isi = rd.isi_min;
    for (int j = 0; j < 10; j++) begin
      cyc(0, 1'($urandom_range(0, 1)), 1, 1'($urandom_range(0, 1)), 0);
      chk("bp_valid", 32'(rd.rate_valid), 1);
      chk("bp_rate", 32'(rd.rate), 32'(hold_rate));
      chk("bp_isi", 32'(rd.isi_min), 32'(hold_isi));
    end
    chk("bp_missed", 32'(missed), 1);
    cyc(0, 0, 0, 0, 1);
    chk("bp_vdrop", 32'(rd.rate_valid), 0);

    // continuous mode, 50% duty, start during COUNT ignored
    cyc(1, 0, 0, 0, 0);
    cyc(0, 1, 0, 1, 1);
    for (int i = 0; i < 3 * (W + 1); i++) begin
      int p;
      p = i % (W + 1);
      cyc(0, p == 5, (p < W) && (p % 2 == 0), 1, 1);
      if (p == W - 1) begin
        chk("cont_valid", 32'(rd.rate_valid), 1);
        chk("cont_rate", 32'(rd.rate), 16);
      end else begin
        chk("cont_novalid", 32'(rd.rate_valid), 0);
      end
    end

    // reset mid-COUNT
    cyc(1, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 1);
    for (int j = 0; j < 10; j++) cyc(0, 0, 1, 0, 1);
    cyc(1, 0, 1, 0, 1);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_rate", 32'(rd.rate), 0);
    for (int j = 0; j < 40; j++) begin
      cyc(0, 0, 0, 0, 1);
      chk("mid_rst_novalid", 32'(rd.rate_valid), 0);
    end

    // single spike
    cyc(0, 1, 0, 0, 0);
    for (int j = 0; j < W; j++) cyc(0, 0, j == 7, 0, 0);
    chk("one_rate", 32'(rd.rate), 1);
    chk("one_isi", 32'(rd.isi_min), 0);
    cyc(0, 0, 0, 0, 1);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      int dens;
      dens = (i / 500) % 3;
      cyc($urandom_range(0, 199) == 0,
          $urandom_range(0, 7) == 0,
          $urandom_range(0, 3) < dens + 1,
          1'($urandom_range(0, 1)),
          $urandom_range(0, 2) != 0);
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
